// File: rtl/hog_stream_pkg.sv
// hog_stream_pkg: shared HOG window stream frame definition for serializer and deserializer
package hog_stream_pkg;
  localparam int WINDOW_WIDTH = 1152;
  localparam int BUS_WIDTH = 32;
  localparam int META_WIDTH = 3;
  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam int HDR_SYNC_MSB = BUS_WIDTH - 1;
  localparam int HDR_SYNC_LSB = BUS_WIDTH - 8;
  localparam int HDR_META_LSB = 0;
  typedef enum logic [1:0] {HEADER, PAYLOAD, FULL} state_e;
  function automatic int frame_words(input int win_w, input int bus_w);
    return win_w / bus_w;
  endfunction
endpackage

// File: rtl/window_deserializer.sv
// window_deserializer: reassembles a header-tagged 32-bit word stream into one HOG window plus level tag
// stream/stream_valid/stream_ready: incoming words; window/metadata/window_valid/window_ready: assembled frame out
// frame_error: pulse per discarded non-header word; error_count: saturating discard count
module window_deserializer #(
  parameter int WINDOW_WIDTH = hog_stream_pkg::WINDOW_WIDTH,
  parameter int BUS_WIDTH = hog_stream_pkg::BUS_WIDTH,
  parameter int META_WIDTH = hog_stream_pkg::META_WIDTH,
  parameter logic [7:0] HDR_SYNC = hog_stream_pkg::HDR_SYNC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    stream,
  input  logic                    stream_valid,
  output logic                    stream_ready,
  output logic [WINDOW_WIDTH-1:0] window,
  output logic [META_WIDTH-1:0]   metadata,
  output logic                    window_valid,
  input  logic                    window_ready,
  output logic                    frame_error,
  output logic [7:0]              error_count
);
  import hog_stream_pkg::*;
  localparam int WORDS = frame_words(WINDOW_WIDTH, BUS_WIDTH);
  localparam int CW = $clog2(WORDS);
  if (WINDOW_WIDTH % BUS_WIDTH != 0) begin : g_chk
    $fatal(1, "WINDOW_WIDTH must be a multiple of BUS_WIDTH");
  end
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [BUS_WIDTH-1:0] word_q [WORDS];
  logic [META_WIDTH-1:0] meta_q;
  logic ready_q, valid_q, frame_error_q;
  logic [7:0] err_q;
  logic accept, sync_ok, last;
  assign accept = stream_valid && ready_q;
  assign sync_ok = stream[BUS_WIDTH-1 -: 8] == HDR_SYNC;
  assign last = cnt_q == CW'(WORDS - 1);
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= HEADER;
      cnt_q <= '0;
      meta_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_q <= '0;
      for (int i = 0; i < WORDS; i++) word_q[i] <= '0;
    end else begin
      frame_error_q <= 1'b0;
      case (state_q)
        HEADER: begin
          ready_q <= 1'b1;
          if (accept && sync_ok) begin
            meta_q <= stream[META_WIDTH-1:0];
            cnt_q <= '0;
            state_q <= PAYLOAD;
          end else if (accept) begin
            frame_error_q <= 1'b1;
            err_q <= err_q + 8'(err_q != 8'hFF);
          end
        end
        PAYLOAD: if (accept) begin
          word_q[cnt_q] <= stream;
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            state_q <= FULL;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        FULL: if (window_ready) begin
          state_q <= HEADER;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
        default: state_q <= HEADER;
      endcase
    end
  for (genvar k = 0; k < WORDS; k++) begin : g_win
    assign window[k*BUS_WIDTH +: BUS_WIDTH] = word_q[k];
  end
  assign stream_ready = ready_q;
  assign metadata = meta_q;
  assign window_valid = valid_q;
  assign frame_error = frame_error_q;
  assign error_count = err_q;
endmodule
